// File: rtl/axi4_lite_master_pkg.sv
// Shared types and constants for the AXI4-lite register master.
// Holds the FSM state encoding, the AXI response codes and the default protection value.
package axi4_lite_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RSP
    } state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    // States in which the master is waiting on the slave and the watchdog runs.
    function automatic logic is_wait_state(input state_t s);
        return (s == WR) || (s == WR_RESP) || (s == RD_ADDR) || (s == RD_DATA);
    endfunction

endpackage

// File: rtl/axi4_lite_watchdog.sv
// Saturating wait-cycle counter with a sticky timeout flag.
// TIMEOUT of 0 disables the flag entirely.
module axi4_lite_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic aclk,
    input  logic areset,
    input  logic restart,
    input  logic active,
    input  logic clear,
    output logic timeout
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic ENABLED = (TIMEOUT != 0);

    logic [CW-1:0] count;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            count <= '0;
        end else if (restart) begin
            count <= '0;
        end else if (active && (count != LIMIT)) begin
            count <= count + CW'(1);
        end
    end

    // The flag survives the end of the wait so the response can report it.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            timeout <= 1'b0;
        end else if (clear) begin
            timeout <= 1'b0;
        end else if (ENABLED && active && (count == LIMIT)) begin
            timeout <= 1'b1;
        end
    end

endmodule

// File: rtl/axi4_lite_register_master.sv
// AXI4-lite master turning a command/response handshake into single register
// reads and writes, one transaction outstanding, with a slave-hang watchdog.
module axi4_lite_register_master
    import axi4_lite_master_pkg::*;
#(
    parameter int A       = 32,
    parameter int N       = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic           aclk,
    input  logic           areset,

    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic           cmd_write,
    input  logic [A-1:0]   cmd_addr,
    input  logic [N*8-1:0] cmd_wdata,
    input  logic [N-1:0]   cmd_wstrb,

    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_write,
    output logic [N*8-1:0] rsp_rdata,
    output logic [1:0]     rsp_resp,
    output logic           timeout,

    output logic [A-1:0]   awaddr,
    output logic [2:0]     awprot,
    output logic           awvalid,
    input  logic           awready,

    output logic [N*8-1:0] wdata,
    output logic [N-1:0]   wstrb,
    output logic           wvalid,
    input  logic           wready,

    input  logic [1:0]     bresp,
    input  logic           bvalid,
    output logic           bready,

    output logic [A-1:0]   araddr,
    output logic [2:0]     arprot,
    output logic           arvalid,
    input  logic           arready,

    input  logic [N*8-1:0] rdata,
    input  logic [1:0]     rresp,
    input  logic           rvalid,
    output logic           rready
);

    state_t state;
    state_t state_n;

    logic [A-1:0]   addr_q;
    logic [N*8-1:0] wdata_q;
    logic [N-1:0]   wstrb_q;
    logic           aw_done;
    logic           w_done;
    logic           rsp_write_q;
    logic [N*8-1:0] rsp_rdata_q;
    logic [1:0]     rsp_resp_q;
    logic           accept;

    assign accept = (state == IDLE) && cmd_valid;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // AW and W complete independently; leave WR only once both have been taken.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (cmd_valid) state_n = cmd_write ? WR : RD_ADDR;
            WR:      if ((aw_done || awready) && (w_done || wready)) state_n = WR_RESP;
            WR_RESP: if (bvalid) state_n = RSP;
            RD_ADDR: if (arready) state_n = RD_DATA;
            RD_DATA: if (rvalid) state_n = RSP;
            RSP:     if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= OKAY;
        end else begin
            if (accept) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (state == WR) begin
                if (awvalid && awready) aw_done <= 1'b1;
                if (wvalid && wready)   w_done  <= 1'b1;
            end
            if ((state == WR_RESP) && bvalid) begin
                rsp_write_q <= 1'b1;
                rsp_rdata_q <= '0;
                rsp_resp_q  <= bresp;
            end
            if ((state == RD_DATA) && rvalid) begin
                rsp_write_q <= 1'b0;
                rsp_rdata_q <= rdata;
                rsp_resp_q  <= rresp;
            end
        end
    end

    // Every output comes from state or registers, never straight from an input.
    assign cmd_ready = (state == IDLE);
    assign awvalid   = (state == WR) && !aw_done;
    assign wvalid    = (state == WR) && !w_done;
    assign bready    = (state == WR_RESP);
    assign arvalid   = (state == RD_ADDR);
    assign rready    = (state == RD_DATA);
    assign rsp_valid = (state == RSP);

    assign awaddr    = addr_q;
    assign araddr    = addr_q;
    assign awprot    = PROT_DEFAULT;
    assign arprot    = PROT_DEFAULT;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;

    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;

    axi4_lite_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .aclk    (aclk),
        .areset  (areset),
        .restart ((state_n != state) && is_wait_state(state_n)),
        .active  (is_wait_state(state)),
        .clear   (accept),
        .timeout (timeout)
    );

endmodule

// File: tb/tb_axi4_lite_register_master.sv
// Scoreboard bench for axi4_lite_register_master: directed commands push expected
// responses, a monitor pops them, and a small slave model answers the AXI channels.
module tb_axi4_lite_register_master;
    import axi4_lite_master_pkg::*;

    logic        aclk;
    logic        areset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        timeout;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, arvalid, arready, rvalid, rready;

    axi4_lite_register_master #(.A(32), .N(4), .TIMEOUT(16)) dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .timeout(timeout),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    typedef struct {
        logic        write;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        tmo;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;
    int rsp_cnt = 0;
    int aw_cnt = 0, w_cnt = 0;
    int accept_cyc = 0, aw_cyc = 0, w_cyc = 0, ar_cyc = 0;
    int rsp_first_cyc = 0, bready_rise_cyc = 0, timeout_rise_cyc = 0;

    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] cfg_rdata;
    logic [1:0]  cfg_bresp, cfg_rresp;
    logic        cfg_b_hold;

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial forever begin
        @(posedge aclk);
        cyc++;
    end

    initial begin
        #100000;
        $display("[TB] FAIL global_time_limit: simulation still running at %0t", $time);
        $fatal(1, "[TB] time limit");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic failWait(input string name);
        nChecks++;
        nFails++;
        $display("[TB] FAIL %s: wait bound expired at cycle %0d (got no event, expected one)", name, cyc);
    endtask

    // Issue one command; caller is positioned just after a rising edge.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [3:0] strb, input logic [31:0] x_rdata,
                                 input logic [1:0] x_resp, input logic x_tmo, input bit push);
        bit got;
        exp_addr  = addr;
        exp_wdata = wd;
        exp_wstrb = strb;
        if (push) sb.push_back('{write: wr, rdata: x_rdata, resp: x_resp, tmo: x_tmo});
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        cmd_wstrb = strb;
        cmd_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge aclk);
            got = cmd_ready;
        end
        if (!got) failWait("cmd_accept");
        @(posedge aclk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic waitRsp();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge aclk);
            done = (sb.size() == 0);
        end
        if (!done) failWait("response_drain");
    endtask

    // Slave model: zero-wait B/R one cycle after the request handshakes complete.
    logic got_aw, got_w;
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
    initial begin
        bvalid = 1'b0; rvalid = 1'b0; bresp = OKAY; rresp = OKAY; rdata = '0;
        got_aw = 1'b0; got_w = 1'b0;
        forever begin
            @(negedge aclk);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            b_hs  = bvalid && bready;
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            if (aw_hs) begin
                aw_cnt++;
                aw_cyc = cyc;
                checkOutput("awaddr", awaddr, exp_addr);
                checkOutput("awprot", awprot, 3'b000);
            end
            if (w_hs) begin
                w_cnt++;
                w_cyc = cyc;
                checkOutput("wdata", wdata, exp_wdata);
                checkOutput("wstrb", wstrb, exp_wstrb);
            end
            if (ar_hs) begin
                ar_cyc = cyc;
                checkOutput("araddr", araddr, exp_addr);
            end
            @(posedge aclk);
            #1;
            if (areset) begin
                bvalid = 1'b0; rvalid = 1'b0; got_aw = 1'b0; got_w = 1'b0;
            end else begin
                if (b_hs) bvalid = 1'b0;
                if (r_hs) rvalid = 1'b0;
                if (aw_hs) got_aw = 1'b1;
                if (w_hs)  got_w  = 1'b1;
                if (got_aw && got_w && !bvalid && !cfg_b_hold) begin
                    bvalid = 1'b1; bresp = cfg_bresp; got_aw = 1'b0; got_w = 1'b0;
                end
                if (ar_hs) begin
                    rvalid = 1'b1; rdata = cfg_rdata; rresp = cfg_rresp;
                end
            end
        end
    end

    // Monitor: scoreboard pops on response handshake plus valid-stability checks.
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_arvalid, m_arready;
    logic        m_rsp_valid, m_rsp_ready, m_rsp_write, m_bready, m_timeout;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rsp_rdata;
    logic [1:0]  m_rsp_resp;
    initial begin
        m_awvalid = 0; m_awready = 0; m_wvalid = 0; m_wready = 0; m_arvalid = 0; m_arready = 0;
        m_rsp_valid = 0; m_rsp_ready = 0; m_rsp_write = 0; m_bready = 0; m_timeout = 0;
        m_awaddr = 0; m_wdata = 0; m_araddr = 0; m_rsp_rdata = 0; m_rsp_resp = 0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                m_awvalid = 0; m_wvalid = 0; m_arvalid = 0; m_rsp_valid = 0;
                m_bready = 0; m_timeout = 0;
            end else begin
                if (cmd_valid && cmd_ready) accept_cyc = cyc;
                if (bready && !m_bready) bready_rise_cyc = cyc;
                if (timeout && !m_timeout) timeout_rise_cyc = cyc;
                if (rsp_valid && !m_rsp_valid) rsp_first_cyc = cyc;
                if (m_awvalid && !m_awready) begin
                    checkOutput("awvalid_hold", awvalid, 1);
                    checkOutput("awaddr_hold", awaddr, m_awaddr);
                end
                if (m_wvalid && !m_wready) begin
                    checkOutput("wvalid_hold", wvalid, 1);
                    checkOutput("wdata_hold", wdata, m_wdata);
                end
                if (m_arvalid && !m_arready) begin
                    checkOutput("arvalid_hold", arvalid, 1);
                    checkOutput("araddr_hold", araddr, m_araddr);
                end
                if (m_rsp_valid && !m_rsp_ready) begin
                    checkOutput("rsp_valid_hold", rsp_valid, 1);
                    checkOutput("rsp_rdata_hold", rsp_rdata, m_rsp_rdata);
                    checkOutput("rsp_resp_hold", rsp_resp, m_rsp_resp);
                    checkOutput("rsp_write_hold", rsp_write, m_rsp_write);
                end
                if (rsp_valid) checkOutput("cmd_ready_during_rsp", cmd_ready, 0);
                if (rsp_valid && rsp_ready) begin
                    rsp_cnt++;
                    if (sb.size() == 0) begin
                        failWait("unexpected_response");
                    end else begin
                        e = sb.pop_front();
                        checkOutput("rsp_write", rsp_write, e.write);
                        checkOutput("rsp_rdata", rsp_rdata, e.rdata);
                        checkOutput("rsp_resp", rsp_resp, e.resp);
                        checkOutput("rsp_timeout", timeout, e.tmo);
                    end
                end
                m_awvalid = awvalid; m_awready = awready; m_awaddr = awaddr;
                m_wvalid = wvalid; m_wready = wready; m_wdata = wdata;
                m_arvalid = arvalid; m_arready = arready; m_araddr = araddr;
                m_rsp_valid = rsp_valid; m_rsp_ready = rsp_ready; m_rsp_write = rsp_write;
                m_rsp_rdata = rsp_rdata; m_rsp_resp = rsp_resp;
                m_bready = bready; m_timeout = timeout;
            end
        end
    end

    int acc;
    int rcyc;
    bit seen;
    initial begin
        areset = 1'b1;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 1; awready = 1; wready = 1; arready = 1;
        cfg_rdata = 0; cfg_bresp = OKAY; cfg_rresp = OKAY; cfg_b_hold = 0;
        exp_addr = 0; exp_wdata = 0; exp_wstrb = 0;
        repeat (2) @(negedge aclk);
        checkOutput("reset_cmd_ready", cmd_ready, 1);
        checkOutput("reset_awvalid", awvalid, 0);
        checkOutput("reset_wvalid", wvalid, 0);
        checkOutput("reset_arvalid", arvalid, 0);
        checkOutput("reset_bready", bready, 0);
        checkOutput("reset_rready", rready, 0);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_timeout", timeout, 0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 0);
        checkOutput("reset_awaddr", awaddr, 0);
        areset = 1'b0;

        $display("[TB] zero-wait write");
        @(posedge aclk); #1;
        applyStimulus(1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 32'h0, OKAY, 0, 1);
        acc = accept_cyc;
        waitRsp();
        checkOutput("wr0_aw_cycle", aw_cyc - acc, 1);
        checkOutput("wr0_w_cycle", w_cyc - acc, 1);
        checkOutput("wr0_rsp_cycle", rsp_first_cyc - acc, 3);

        $display("[TB] write with late wready");
        @(posedge aclk); #1;
        aw_cnt = 0; w_cnt = 0; wready = 0;
        applyStimulus(1, 32'h0000_0010, 32'hCAFE_F00D, 4'h5, 32'h0, OKAY, 0, 1);
        acc = accept_cyc;
        @(negedge aclk);
        checkOutput("wr1_awvalid_c1", awvalid, 1);
        checkOutput("wr1_wvalid_c1", wvalid, 1);
        @(negedge aclk);
        checkOutput("wr1_awvalid_c2", awvalid, 0);
        checkOutput("wr1_wvalid_c2", wvalid, 1);
        @(posedge aclk);
        @(posedge aclk); #1;
        wready = 1;
        waitRsp();
        checkOutput("wr1_aw_cycle", aw_cyc - acc, 1);
        checkOutput("wr1_w_cycle", w_cyc - acc, 4);
        checkOutput("wr1_bready_cycle", bready_rise_cyc - acc, 5);
        checkOutput("wr1_aw_count", aw_cnt, 1);
        checkOutput("wr1_w_count", w_cnt, 1);
        checkOutput("wr1_rsp_cycle", rsp_first_cyc - acc, 6);

        $display("[TB] read with SLVERR");
        @(posedge aclk); #1;
        cfg_rdata = 32'h1234_5678; cfg_rresp = SLVERR;
        applyStimulus(0, 32'h0000_0004, 32'h0, 4'h0, 32'h1234_5678, SLVERR, 0, 1);
        acc = accept_cyc;
        waitRsp();
        checkOutput("rd0_ar_cycle", ar_cyc - acc, 1);
        checkOutput("rd0_rsp_cycle", rsp_first_cyc - acc, 3);

        $display("[TB] response backpressure then back-to-back read");
        @(posedge aclk); #1;
        rsp_ready = 0; cfg_bresp = DECERR;
        applyStimulus(1, 32'h0000_0020, 32'h0BAD_CAFE, 4'h3, 32'h0, DECERR, 0, 1);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge aclk);
            seen = rsp_valid;
        end
        if (!seen) failWait("bp_rsp_valid");
        repeat (10) @(negedge aclk);
        @(posedge aclk); #1;
        rcyc = cyc;
        rsp_ready = 1; cfg_bresp = OKAY;
        cfg_rdata = 32'h0F0F_A5A5; cfg_rresp = EXOKAY;
        applyStimulus(0, 32'h0000_0004, 32'h0, 4'h0, 32'h0F0F_A5A5, EXOKAY, 0, 1);
        checkOutput("b2b_accept_cycle", accept_cyc, rcyc + 1);
        waitRsp();

        $display("[TB] watchdog on stuck arready");
        @(posedge aclk); #1;
        arready = 0; cfg_rdata = 32'h5555_AAAA; cfg_rresp = OKAY;
        applyStimulus(0, 32'h0000_0040, 32'h0, 4'h0, 32'h5555_AAAA, OKAY, 1, 1);
        acc = accept_cyc;
        repeat (16) @(negedge aclk);
        checkOutput("wd_timeout_before", timeout, 0);
        @(negedge aclk);
        checkOutput("wd_timeout_fired", timeout, 1);
        checkOutput("wd_arvalid_held", arvalid, 1);
        checkOutput("wd_rise_cycle", timeout_rise_cyc - acc, 17);
        repeat (5) @(negedge aclk);
        checkOutput("wd_timeout_sticky", timeout, 1);
        @(posedge aclk); #1;
        arready = 1;
        waitRsp();
        @(posedge aclk); #1;
        applyStimulus(1, 32'h0000_0044, 32'h0000_0001, 4'h1, 32'h0, OKAY, 0, 1);
        @(negedge aclk);
        checkOutput("wd_cleared_on_accept", timeout, 0);
        waitRsp();

        $display("[TB] reset during WR_RESP");
        @(posedge aclk); #1;
        cfg_b_hold = 1;
        applyStimulus(1, 32'h0000_0030, 32'h1111_2222, 4'hF, 32'h0, OKAY, 0, 0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge aclk);
            seen = bready;
        end
        if (!seen) failWait("rst_bready");
        #2;
        areset = 1;
        #1;
        checkOutput("rst_awvalid", awvalid, 0);
        checkOutput("rst_wvalid", wvalid, 0);
        checkOutput("rst_bready", bready, 0);
        checkOutput("rst_arvalid", arvalid, 0);
        checkOutput("rst_rready", rready, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_awaddr", awaddr, 0);
        checkOutput("rst_wdata", wdata, 0);
        repeat (2) @(negedge aclk);
        areset = 0;
        cfg_b_hold = 0;
        @(negedge aclk);
        checkOutput("rst_cmd_ready_after", cmd_ready, 1);
        checkOutput("rst_bready_after", bready, 0);
        @(posedge aclk); #1;
        cfg_rdata = 32'h8765_4321; cfg_rresp = OKAY;
        applyStimulus(0, 32'h0000_0008, 32'h0, 4'h0, 32'h8765_4321, OKAY, 0, 1);
        acc = accept_cyc;
        waitRsp();
        checkOutput("rst_rd_ar_cycle", ar_cyc - acc, 1);
        checkOutput("rst_rd_rsp_cycle", rsp_first_cyc - acc, 3);

        repeat (3) @(negedge aclk);
        checkOutput("rsp_total", rsp_cnt, 8);
        checkOutput("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
